// File: rtl/div_pkg.sv
`default_nettype none
// ============================================================================
// Module      : div_pkg
// Description : Shared types and helpers for the sequential divider:
//               FSM state encoding and iteration-counter width.
// Revision    : 1.0 - initial release
// ============================================================================
package div_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    // Bits needed to count iterations 0..n-1 (never narrower than one bit)
    function automatic int cnt_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage
`default_nettype wire

// File: rtl/div_step.sv
`default_nettype none
// ============================================================================
// Module      : div_step
// Description : One radix-2 restoring iteration. Shifts the next dividend bit
//               into the partial remainder, trial-subtracts the divisor and
//               keeps the difference only when it does not go negative.
// Revision    : 1.0 - initial release
// ============================================================================
module div_step #(
    parameter int N = 8
) (
    input  logic [N:0]   part_rem,
    input  logic         shift_in,
    input  logic [N-1:0] divisor,
    output logic [N:0]   next_rem,
    output logic         q_bit
);

    logic [N+1:0] w_trial;
    logic [N:0]   w_diff;

    // Shift, compare, then restore or keep the difference
    always_comb begin
        w_trial  = {part_rem, shift_in};
        q_bit    = (w_trial >= {2'b00, divisor});
        w_diff   = w_trial[N:0] - {1'b0, divisor};
        next_rem = q_bit ? w_diff : w_trial[N:0];
    end

endmodule
`default_nettype wire

// File: rtl/seq_divider.sv
`default_nettype none
// ============================================================================
// Module      : seq_divider
// Description : Multi-cycle radix-2 restoring divider, one quotient bit per
//               clock. Results are written on the edge entering DONE; stop
//               pulses one cycle later. Divide-by-zero bypasses iteration.
//               Optional macro SEQ_DIVIDER_SIGNED_EN enables two's-complement
//               operation selected by op_signed.
// Revision    : 1.0 - initial release
// ============================================================================
module seq_divider
    import div_pkg::*;
#(
    parameter int N = 8
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         start,
    input  logic         op_signed,
    input  logic [N-1:0] devidend,
    input  logic [N-1:0] devisor,
    output logic         ready,
    output logic [N-1:0] quo,
    output logic [N-1:0] rem,
    output logic         stop,
    output logic         dbz
);

    localparam int CW = cnt_width(N);

    state_t        r_state;
    state_t        w_next;
    logic [CW-1:0] r_cnt;
    logic [N:0]    r_pr;
    logic [N-1:0]  r_aq;
    logic [N-1:0]  r_d;

    logic          w_accept;
    logic          w_last;
    logic [N-1:0]  w_dvd_mag;
    logic [N-1:0]  w_dvs_mag;
    logic [N:0]    w_next_rem;
    logic          w_q_bit;
    logic [N-1:0]  w_q_final;
    logic [N-1:0]  w_quo_fix;
    logic [N-1:0]  w_rem_fix;

`ifdef SEQ_DIVIDER_SIGNED_EN
    logic          r_neg_q;
    logic          r_neg_r;
    logic          w_dvd_neg;
    logic          w_dvs_neg;
`else
    logic          w_unused_sign;
`endif

    assign w_accept  = (r_state == IDLE) && start;
    assign w_last    = (r_cnt == CW'(N - 1));
    assign w_q_final = {r_aq[N-2:0], w_q_bit};

    div_step #(.N(N)) u_step (
        .part_rem (r_pr),
        .shift_in (r_aq[N-1]),
        .divisor  (r_d),
        .next_rem (w_next_rem),
        .q_bit    (w_q_bit)
    );

    // Operand magnitudes at acceptance and sign restoration of the final result
    always_comb begin
`ifdef SEQ_DIVIDER_SIGNED_EN
        w_dvd_neg = op_signed && devidend[N-1];
        w_dvs_neg = op_signed && devisor[N-1];
        w_dvd_mag = w_dvd_neg ? (~devidend + 1'b1) : devidend;
        w_dvs_mag = w_dvs_neg ? (~devisor + 1'b1) : devisor;
        w_quo_fix = r_neg_q ? (~w_q_final + 1'b1) : w_q_final;
        w_rem_fix = r_neg_r ? (~w_next_rem[N-1:0] + 1'b1) : w_next_rem[N-1:0];
`else
        w_unused_sign = op_signed;
        w_dvd_mag     = devidend;
        w_dvs_mag     = devisor;
        w_quo_fix     = w_q_final;
        w_rem_fix     = w_next_rem[N-1:0];
`endif
    end

    // State register
    always_ff @(posedge clk) begin
        if (!reset_n) r_state <= IDLE;
        else          r_state <= w_next;
    end

    // Next-state decode; ready is asserted only while idle
    always_comb begin
        w_next = r_state;
        ready  = 1'b0;
        case (r_state)
            IDLE: begin
                ready = 1'b1;
                if (start) w_next = (devisor == '0) ? DONE : CALC;
            end
            CALC:    if (w_last) w_next = DONE;
            DONE:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // Iteration datapath: load magnitudes on acceptance, shift/subtract in CALC
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_pr  <= '0;
            r_aq  <= '0;
            r_d   <= '0;
            r_cnt <= '0;
`ifdef SEQ_DIVIDER_SIGNED_EN
            r_neg_q <= 1'b0;
            r_neg_r <= 1'b0;
`endif
        end else if (w_accept) begin
            r_pr  <= '0;
            r_aq  <= w_dvd_mag;
            r_d   <= w_dvs_mag;
            r_cnt <= '0;
`ifdef SEQ_DIVIDER_SIGNED_EN
            r_neg_q <= w_dvd_neg ^ w_dvs_neg;
            r_neg_r <= w_dvd_neg;
`endif
        end else if (r_state == CALC) begin
            r_pr  <= w_next_rem;
            r_aq  <= w_q_final;
            r_cnt <= r_cnt + CW'(1);
        end
    end

    // Result registers change only on the edge entering DONE
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            quo <= '0;
            rem <= '0;
            dbz <= 1'b0;
        end else if (w_accept && (devisor == '0)) begin
            quo <= '1;
            rem <= devidend;
            dbz <= 1'b1;
        end else if ((r_state == CALC) && w_last) begin
            quo <= w_quo_fix;
            rem <= w_rem_fix;
            dbz <= 1'b0;
        end
    end

    // Completion pulse one cycle after DONE; reset suppresses it
    always_ff @(posedge clk) begin
        if (!reset_n) stop <= 1'b0;
        else          stop <= (r_state == DONE);
    end

endmodule
`default_nettype wire

// File: tb/tb_seq_divider.sv
`default_nettype none
// ============================================================================
// Module      : tb_seq_divider
// Description : Scoreboard bench for seq_divider (N=8). Expected results are
//               computed with native arithmetic when a request is issued and
//               compared when stop is observed.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_seq_divider;

    localparam int N = 8;

    logic         clk       = 1'b0;
    logic         reset_n   = 1'b0;
    logic         start     = 1'b0;
    logic         op_signed = 1'b0;
    logic [N-1:0] devidend  = '0;
    logic [N-1:0] devisor   = '0;
    logic         ready;
    logic         stop;
    logic         dbz;
    logic [N-1:0] quo;
    logic [N-1:0] rem;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [N-1:0] q;
        logic [N-1:0] r;
        logic         z;
        int           lat;
    } exp_t;

    exp_t sb_q[$];

    seq_divider #(.N(N)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .start     (start),
        .op_signed (op_signed),
        .devidend  (devidend),
        .devisor   (devisor),
        .ready     (ready),
        .quo       (quo),
        .rem       (rem),
        .stop      (stop),
        .dbz       (dbz)
    );

    always #5 clk = ~clk;

    // Reference model: native division, pushed when the request is issued
    function automatic void push_exp(input logic [N-1:0] a, input logic [N-1:0] b, input logic s);
        exp_t e;
        int   sa;
        int   sb;
        logic use_signed;
`ifdef SEQ_DIVIDER_SIGNED_EN
        use_signed = s;
`else
        use_signed = 1'b0 & s;
`endif
        e.z   = 1'b0;
        e.lat = N + 1;
        e.q   = '0;
        e.r   = '0;
        if (b == '0) begin
            e.q   = '1;
            e.r   = a;
            e.z   = 1'b1;
            e.lat = 1;
        end else if (use_signed) begin
            sa  = $signed(a);
            sb  = $signed(b);
            e.q = N'(sa / sb);
            e.r = N'(sa % sb);
        end else begin
            e.q = a / b;
            e.r = a % b;
        end
        sb_q.push_back(e);
    endfunction

    // Issue one request and wait (bounded) for its stop pulse
    task automatic run_op(input logic [N-1:0] a, input logic [N-1:0] b, input logic s,
                          output int lat, output logic [N-1:0] q, output logic [N-1:0] r,
                          output logic z, output logic stop_after);
        int w;
        w = 0;
        while (!ready && w < 100) begin
            @(posedge clk); #1; w++;
        end
        devidend  = a;
        devisor   = b;
        op_signed = s;
        start     = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        lat   = 0;
        while (!stop && lat < 100) begin
            @(posedge clk); #1; lat++;
        end
        q = quo;
        r = rem;
        z = dbz;
        @(posedge clk); #1;
        stop_after = stop;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b expected 1", ready); end
        checks++; if (quo !== '0) begin errors++; $display("FAIL reset_quo: got %0h expected 0", quo); end
        checks++; if (rem !== '0) begin errors++; $display("FAIL reset_rem: got %0h expected 0", rem); end
        checks++; if (dbz !== 1'b0) begin errors++; $display("FAIL reset_dbz: got %b expected 0", dbz); end
        checks++; if (stop !== 1'b0) begin errors++; $display("FAIL reset_stop: got %b expected 0", stop); end
        reset_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_unsigned();
        logic [N-1:0] ta[5] = '{8'd14, 8'd255, 8'd200, 8'd7, 8'd255};
        logic [N-1:0] tb[5] = '{8'd4, 8'd1, 8'd7, 8'd200, 8'd255};
        int lat; logic [N-1:0] q, r; logic z, sa; exp_t e;
        for (int i = 0; i < 5; i++) begin
            push_exp(ta[i], tb[i], 1'b0);
            run_op(ta[i], tb[i], 1'b0, lat, q, r, z, sa);
            e = sb_q.pop_front();
            checks++; if (lat !== e.lat) begin errors++; $display("FAIL uns_latency[%0d]: got %0d expected %0d", i, lat, e.lat); end
            checks++; if (q !== e.q) begin errors++; $display("FAIL uns_quo[%0d]: got %0h expected %0h", i, q, e.q); end
            checks++; if (r !== e.r) begin errors++; $display("FAIL uns_rem[%0d]: got %0h expected %0h", i, r, e.r); end
            checks++; if (z !== e.z) begin errors++; $display("FAIL uns_dbz[%0d]: got %b expected %b", i, z, e.z); end
            checks++; if (sa !== 1'b0) begin errors++; $display("FAIL uns_stop_width[%0d]: got %b expected 0", i, sa); end
        end
    endtask

    task automatic test_signed();
        logic [N-1:0] ta[4] = '{8'hF3, 8'd13, 8'h80, 8'hF3};
        logic [N-1:0] tb[4] = '{8'd3, 8'hFD, 8'hFF, 8'h03};
        int lat; logic [N-1:0] q, r; logic z, sa; exp_t e;
        for (int i = 0; i < 4; i++) begin
            push_exp(ta[i], tb[i], 1'b1);
            run_op(ta[i], tb[i], 1'b1, lat, q, r, z, sa);
            e = sb_q.pop_front();
            checks++; if (lat !== e.lat) begin errors++; $display("FAIL sgn_latency[%0d]: got %0d expected %0d", i, lat, e.lat); end
            checks++; if (q !== e.q) begin errors++; $display("FAIL sgn_quo[%0d]: got %0h expected %0h", i, q, e.q); end
            checks++; if (r !== e.r) begin errors++; $display("FAIL sgn_rem[%0d]: got %0h expected %0h", i, r, e.r); end
            checks++; if (z !== 1'b0) begin errors++; $display("FAIL sgn_dbz[%0d]: got %b expected 0", i, z); end
        end
    endtask

    task automatic test_zero_div();
        int lat; logic [N-1:0] q, r; logic z, sa; exp_t e;
        push_exp(8'd200, 8'd0, 1'b0);
        run_op(8'd200, 8'd0, 1'b0, lat, q, r, z, sa);
        e = sb_q.pop_front();
        checks++; if (lat !== e.lat) begin errors++; $display("FAIL dbz_latency: got %0d expected %0d", lat, e.lat); end
        checks++; if (q !== e.q) begin errors++; $display("FAIL dbz_quo: got %0h expected %0h", q, e.q); end
        checks++; if (r !== e.r) begin errors++; $display("FAIL dbz_rem: got %0h expected %0h", r, e.r); end
        checks++; if (z !== e.z) begin errors++; $display("FAIL dbz_flag: got %b expected %b", z, e.z); end
        checks++; if (sa !== 1'b0) begin errors++; $display("FAIL dbz_stop_width: got %b expected 0", sa); end
        repeat (3) @(posedge clk);
        #1;
        checks++; if (quo !== e.q || rem !== e.r || dbz !== e.z) begin
            errors++; $display("FAIL dbz_hold: got %0h/%0h/%b expected %0h/%0h/%b", quo, rem, dbz, e.q, e.r, e.z);
        end
    endtask

    task automatic test_back_to_back();
        int cnt; exp_t e;
        push_exp(8'd50, 8'd6, 1'b0);
        push_exp(8'd99, 8'd5, 1'b0);
        devidend = 8'd50; devisor = 8'd6; op_signed = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        devidend = 8'd99; devisor = 8'd5;
        checks++; if (ready !== 1'b0) begin errors++; $display("FAIL b2b_ready_calc: got %b expected 0", ready); end
        cnt = 0;
        while (!stop && cnt < 100) begin @(posedge clk); #1; cnt++; end
        e = sb_q.pop_front();
        checks++; if (cnt !== e.lat) begin errors++; $display("FAIL b2b_first_latency: got %0d expected %0d", cnt, e.lat); end
        checks++; if (quo !== e.q || rem !== e.r || dbz !== e.z) begin
            errors++; $display("FAIL b2b_first_result: got %0h/%0h/%b expected %0h/%0h/%b", quo, rem, dbz, e.q, e.r, e.z);
        end
        cnt = 0;
        do begin
            @(posedge clk); #1; cnt++;
            if (cnt == 1) start = 1'b0;
        end while (!stop && cnt < 100);
        e = sb_q.pop_front();
        checks++; if (cnt !== e.lat + 1) begin errors++; $display("FAIL b2b_second_latency: got %0d expected %0d", cnt, e.lat + 1); end
        checks++; if (quo !== e.q || rem !== e.r || dbz !== e.z) begin
            errors++; $display("FAIL b2b_second_result: got %0h/%0h/%b expected %0h/%0h/%b", quo, rem, dbz, e.q, e.r, e.z);
        end
        start = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_reset_abort();
        int lat, seen; logic [N-1:0] q, r; logic z, sa; exp_t e;
        devidend = 8'd255; devisor = 8'd1; op_signed = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        reset_n = 1'b0;
        @(posedge clk); #1;
        reset_n = 1'b1;
        checks++; if (quo !== '0 || rem !== '0 || dbz !== 1'b0) begin
            errors++; $display("FAIL abort_outputs: got %0h/%0h/%b expected 0/0/0", quo, rem, dbz);
        end
        checks++; if (ready !== 1'b1) begin errors++; $display("FAIL abort_ready: got %b expected 1", ready); end
        seen = 0;
        for (int i = 0; i < 12; i++) begin
            if (stop) seen++;
            @(posedge clk); #1;
        end
        checks++; if (seen !== 0) begin errors++; $display("FAIL abort_no_stop: got %0d pulses expected 0", seen); end
        push_exp(8'd9, 8'd2, 1'b0);
        run_op(8'd9, 8'd2, 1'b0, lat, q, r, z, sa);
        e = sb_q.pop_front();
        checks++; if (lat !== e.lat) begin errors++; $display("FAIL abort_next_latency: got %0d expected %0d", lat, e.lat); end
        checks++; if (q !== e.q || r !== e.r || z !== e.z) begin
            errors++; $display("FAIL abort_next_result: got %0h/%0h/%b expected %0h/%0h/%b", q, r, z, e.q, e.r, e.z);
        end
    endtask

    initial begin
        test_reset();
        test_unsigned();
        test_signed();
        test_zero_div();
        test_back_to_back();
        test_reset_abort();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
